mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ALIGN_CHECK, default 1, meaning 1 enables the address-alignment exception check and 0 disables it (treat all accesses as aligned).
REQ-002 SHALL have clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have flush  input  1  kill the in-flight instruction (exception/eret redirect).
REQ-005 SHALL have in_valid/in_ready  input/output  1/1  execute-result handshake.
REQ-006 SHALL have in_aluout, in_writedata  input  32 each  effective address and store data.
REQ-007 SHALL have in_mem_read, in_mem_write, in_sign_ext  input  1 each; in_size  input  2 (0=byte, 1=half, 2=word); in_exc  input  1 (earlier-stage exception pending); in_writereg  input  5.
REQ-008 SHALL have dreq_valid  output  1; dreq_write  output  1; dreq_addr  output  32; dreq_strobe  output  4; dreq_data  output  32.
REQ-009 SHALL have dresp_addr_ok, dresp_data_ok  input  1 each; dresp_data  input  32.
REQ-010 SHALL have out_valid/out_ready  output/input  1/1; out_result  output  32; out_writereg  output  5; out_adel, out_ades  output  1 each; out_badvaddr  output  32.

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, DATA, DRAIN.
REQ-012 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-013 On accept (in_valid && in_ready), SHALL latch all in_* fields.
REQ-014 Accept of a non-memory op, an op with in_exc=1, or a misaligned op SHALL load the output register at that same edge: out_valid=1 next cycle, state stays IDLE, no bus request.
REQ-015 Misaligned definition: half with addr[0]=1; word with addr[1:0]!=0; load sets out_adel, store sets out_ades, out_badvaddr=in_aluout, out_result=in_aluout.
REQ-016 Accept of an aligned load/store without in_exc SHALL enter ADDR; in ADDR, dreq_valid=1 with dreq_addr/write/strobe/data stable until dresp_addr_ok.
REQ-017 ADDR + addr_ok without data_ok SHALL go to DATA; ADDR + addr_ok + data_ok in the same cycle SHALL complete directly to IDLE.
REQ-018 DATA + data_ok SHALL load the output register (out_valid=1 next cycle) and return to IDLE; dreq_valid=0 in DATA.
REQ-019 Store strobes: byte 4'b0001<<addr[1:0], data {4{wd[7:0]}}; half 4'b0011 (addr[1]=0) or 4'b1100, data {2{wd[15:0]}}; word 4'b1111, data wd.
REQ-020 Load result: byte lane addr[1:0], half lane addr[1], zero- or sign-extended per in_sign_ext; word as-is; store out_result=0.
REQ-021 Output register SHALL hold value until out_valid && out_ready; a new result may load on the same edge it is consumed.
REQ-022 flush in IDLE SHALL clear out_valid; in ADDR before addr_ok SHALL drop dreq_valid next cycle and go IDLE.
REQ-023 flush in DATA, or with addr_ok in ADDR, SHALL go to DRAIN; DRAIN waits for data_ok, discards data, goes IDLE; out_valid never set for a flushed instruction.
REQ-024 flush SHALL take priority over a simultaneous accept (no accept occurs).
REQ-025 Exactly one outstanding bus transaction; no new dreq_valid before the previous data_ok.

Reset
REQ-026 reset asserted SHALL immediately force state=IDLE, out_valid=0, dreq_valid=0, out_adel=0, out_ades=0, out_result=0, out_badvaddr=0, out_writereg=0, in_ready=1 regardless of clock.
REQ-027 Reset mid-transaction SHALL abandon it without waiting for data_ok; the bus side is reset together.

Verification
REQ-028 Load byte, sign_ext=1, addr 0x1003, dresp_data 0x80FF_0000 -> out_result 0xFFFF_FF80, out_valid 3 cycles after accept with addr_ok in ADDR and data_ok 1 cycle later.
REQ-029 Store half addr 0x2002 wd 0x0000_BEEF -> dreq_strobe 4'b1100, dreq_data 0xBEEF_BEEF, dreq_write=1.
REQ-030 Load word addr 0x3001 -> out_adel=1, out_badvaddr 0x3001, dreq_valid never asserted, out_valid 1 cycle after accept.
REQ-031 addr_ok held low 5 cycles -> dreq_valid and dreq_addr stable all 5 cycles; addr_ok+data_ok same cycle -> out_valid next cycle.
REQ-032 flush in DATA, data_ok 2 cycles later -> DRAIN, in_ready=0 until data_ok, out_valid stays 0.
REQ-033 out_ready=0 for 4 cycles with a pending result -> out_result stable, in_ready=0, no new accept.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-bus-side signal bundle for the memory access unit.
// The slave modport is the unit's view; the master modport is its environment.
interface mem_access_unit_if;
  logic        flush;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_aluout;
  logic [31:0] in_writedata;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_sign_ext;
  logic [1:0]  in_size;
  logic        in_exc;
  logic [4:0]  in_writereg;

  logic        dreq_valid;
  logic        dreq_write;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;

  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_writereg;
  logic        out_adel;
  logic        out_ades;
  logic [31:0] out_badvaddr;

  modport slave (
    input  flush,
    input  in_valid, in_aluout, in_writedata, in_mem_read, in_mem_write,
           in_sign_ext, in_size, in_exc, in_writereg,
    output in_ready,
    output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output out_valid, out_result, out_writereg, out_adel, out_ades, out_badvaddr,
    input  out_ready
  );

  modport master (
    output flush,
    output in_valid, in_aluout, in_writedata, in_mem_read, in_mem_write,
           in_sign_ext, in_size, in_exc, in_writereg,
    input  in_ready,
    input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  out_valid, out_result, out_writereg, out_adel, out_ades, out_badvaddr,
    output out_ready
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory stage: turns one execute result into at most one data-bus transaction,
// formats store lanes / load extension, and raises address-error exceptions.
module mem_access_unit #(
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        sign_ext;
    logic [1:0]  size;
    logic [4:0]  writereg;
  } req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result;
    logic [4:0]  writereg;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;
  } out_t;

  state_e state_q, state_d;
  req_t   req_q, req_d;
  out_t   out_q, out_d;

  logic in_ready;
  logic accept;
  logic is_mem;
  logic misaligned;
  logic bypass;
  logic addr_exc;
  logic complete;

  function automatic logic [3:0] strobe_of(input logic [1:0] size, input logic [1:0] a);
    unique case (size)
      2'd0:    strobe_of = 4'b0001 << a;
      2'd1:    strobe_of = a[1] ? 4'b1100 : 4'b0011;
      default: strobe_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data_of(input logic [1:0] size, input logic [31:0] wd);
    unique case (size)
      2'd0:    store_data_of = {4{wd[7:0]}};
      2'd1:    store_data_of = {2{wd[15:0]}};
      default: store_data_of = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_data_of(input logic [1:0] size, input logic [1:0] a,
                                               input logic sext, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = d[{a[1], 4'b0000} +: 16];
    unique case (size)
      2'd0:    load_data_of = {{24{sext & b[7]}}, b};
      2'd1:    load_data_of = {{16{sext & h[15]}}, h};
      default: load_data_of = d;
    endcase
  endfunction

  always_comb begin
    misaligned = 1'b0;
    unique case (bus.in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.in_aluout[0];
      default: misaligned = (bus.in_aluout[1:0] != 2'b00);
    endcase
    if (ALIGN_CHECK == 0) misaligned = 1'b0;
  end

  assign in_ready = (state_q == IDLE) && (!out_q.valid || bus.out_ready);
  // A flush in the same cycle kills the offered instruction before it is taken.
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign is_mem   = bus.in_mem_read || bus.in_mem_write;
  assign addr_exc = is_mem && !bus.in_exc && misaligned;
  assign bypass   = !is_mem || bus.in_exc || misaligned;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: if (accept && !bypass) state_d = ADDR;
      ADDR: begin
        if (bus.flush) begin
          // Once the address is taken the bus owes us a data beat that must be absorbed.
          state_d = (bus.dresp_addr_ok && !bus.dresp_data_ok) ? DRAIN : IDLE;
        end else if (bus.dresp_addr_ok) begin
          if (bus.dresp_data_ok) begin
            state_d  = IDLE;
            complete = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bus.flush)              state_d = bus.dresp_data_ok ? IDLE : DRAIN;
        else if (bus.dresp_data_ok) begin
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      DRAIN: if (bus.dresp_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d.addr     = bus.in_aluout;
      req_d.wdata    = bus.in_writedata;
      req_d.write    = bus.in_mem_write;
      req_d.sign_ext = bus.in_sign_ext;
      req_d.size     = bus.in_size;
      req_d.writereg = bus.in_writereg;
    end
  end

  always_comb begin
    out_d = out_q;
    if (out_q.valid && bus.out_ready) out_d.valid = 1'b0;
    if (bus.flush) begin
      out_d.valid = 1'b0;
    end else if (accept && bypass) begin
      out_d.valid    = 1'b1;
      out_d.result   = bus.in_aluout;
      out_d.writereg = bus.in_writereg;
      out_d.adel     = addr_exc && !bus.in_mem_write;
      out_d.ades     = addr_exc && bus.in_mem_write;
      out_d.badvaddr = addr_exc ? bus.in_aluout : 32'h0;
    end else if (complete) begin
      out_d.valid    = 1'b1;
      out_d.result   = req_q.write ? 32'h0
                     : load_data_of(req_q.size, req_q.addr[1:0], req_q.sign_ext, bus.dresp_data);
      out_d.writereg = req_q.writereg;
      out_d.adel     = 1'b0;
      out_d.ades     = 1'b0;
      out_d.badvaddr = 32'h0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.dreq_valid   = (state_q == ADDR);
  assign bus.dreq_write   = req_q.write;
  assign bus.dreq_addr    = req_q.addr;
  assign bus.dreq_strobe  = req_q.write ? strobe_of(req_q.size, req_q.addr[1:0]) : 4'b0000;
  assign bus.dreq_data    = store_data_of(req_q.size, req_q.wdata);

  assign bus.out_valid    = out_q.valid;
  assign bus.out_result   = out_q.result;
  assign bus.out_writereg = out_q.writereg;
  assign bus.out_adel     = out_q.adel;
  assign bus.out_ades     = out_q.ades;
  assign bus.out_badvaddr = out_q.badvaddr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs change on the falling edge,
// registered outputs are checked on the falling edge after each rising edge.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  mem_access_unit_if bus();

  mem_access_unit #(.ALIGN_CHECK(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic sx, input logic [1:0] sz,
                       input logic exc, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] wreg);
    bus.in_valid     = 1'b1;
    bus.in_mem_read  = rd;
    bus.in_mem_write = wr;
    bus.in_sign_ext  = sx;
    bus.in_size      = sz;
    bus.in_exc       = exc;
    bus.in_aluout    = addr;
    bus.in_writedata = wd;
    bus.in_writereg  = wreg;
  endtask

  task automatic idle_in();
    bus.in_valid     = 1'b0;
    bus.in_mem_read  = 1'b0;
    bus.in_mem_write = 1'b0;
    bus.in_sign_ext  = 1'b0;
    bus.in_size      = 2'd0;
    bus.in_exc       = 1'b0;
    bus.in_aluout    = 32'h0;
    bus.in_writedata = 32'h0;
    bus.in_writereg  = 5'd0;
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    bus.flush         = 1'b0;
    bus.out_ready     = 1'b1;
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = 32'h0;

    // Reset state, observed while reset is held and before any clock edge.
    #2 reset = 1'b1;
    settle();
    check("rst_in_ready",   32'(bus.in_ready), 32'd1);
    check("rst_out_valid",  32'(bus.out_valid), 32'd0);
    check("rst_dreq_valid", 32'(bus.dreq_valid), 32'd0);
    check("rst_adel_ades",  {30'd0, bus.out_adel, bus.out_ades}, 32'd0);
    check("rst_result",     bus.out_result, 32'h0);
    check("rst_badvaddr",   bus.out_badvaddr, 32'h0);
    check("rst_writereg",   32'(bus.out_writereg), 32'd0);
    repeat (2) tick();
    reset = 1'b0;

    // Signed byte load, addr_ok then data_ok one cycle later.
    issue(1, 0, 1, 2'd0, 0, 32'h0000_1003, 32'h0, 5'd5);
    settle();
    check("lb_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle_in();
    check("lb_dreq_valid", 32'(bus.dreq_valid), 32'd1);
    check("lb_dreq_addr",  bus.dreq_addr, 32'h0000_1003);
    check("lb_dreq_write", 32'(bus.dreq_write), 32'd0);
    check("lb_busy_ready", 32'(bus.in_ready), 32'd0);
    bus.dresp_addr_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    check("lb_data_noreq", 32'(bus.dreq_valid), 32'd0);
    check("lb_not_yet",    32'(bus.out_valid), 32'd0);
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 32'h80FF_0000;
    tick();
    bus.dresp_data_ok = 1'b0;
    check("lb_out_valid", 32'(bus.out_valid), 32'd1);
    check("lb_result",    bus.out_result, 32'hFFFF_FF80);
    check("lb_writereg",  32'(bus.out_writereg), 32'd5);
    check("lb_adel",      32'(bus.out_adel), 32'd0);

    // Unsigned byte load from lane 1, issued as the previous result is consumed.
    issue(1, 0, 0, 2'd0, 0, 32'h0000_1001, 32'h0, 5'd6);
    tick();
    idle_in();
    check("lbu_consumed",   32'(bus.out_valid), 32'd0);
    check("lbu_dreq_valid", 32'(bus.dreq_valid), 32'd1);
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 32'h0000_AB00;
    tick();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    check("lbu_result", bus.out_result, 32'h0000_00AB);

    // Halfword store to the upper lane, addr_ok withheld for five cycles.
    issue(0, 1, 0, 2'd1, 0, 32'h0000_2002, 32'h0000_BEEF, 5'd0);
    tick();
    idle_in();
    check("sh_dreq_write",  32'(bus.dreq_write), 32'd1);
    check("sh_dreq_strobe", 32'(bus.dreq_strobe), 32'hC);
    check("sh_dreq_data",   bus.dreq_data, 32'hBEEF_BEEF);
    check("sh_dreq_valid0", 32'(bus.dreq_valid), 32'd1);
    check("sh_dreq_addr0",  bus.dreq_addr, 32'h0000_2002);
    for (int i = 1; i < 5; i++) begin
      tick();
      check("sh_hold_valid",  32'(bus.dreq_valid), 32'd1);
      check("sh_hold_addr",   bus.dreq_addr, 32'h0000_2002);
      check("sh_hold_strobe", 32'(bus.dreq_strobe), 32'hC);
    end
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.out_ready     = 1'b0;
    issue(0, 0, 0, 2'd2, 0, 32'h0000_1234, 32'h0, 5'd7);
    settle();
    check("sh_busy_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    check("sh_out_valid",  32'(bus.out_valid), 32'd1);
    check("sh_result",     bus.out_result, 32'h0);
    check("sh_dreq_idle",  32'(bus.dreq_valid), 32'd0);

    // Back-pressure: result held, no accept while out_ready is low.
    for (int i = 0; i < 4; i++) begin
      check("bp_valid",    32'(bus.out_valid), 32'd1);
      check("bp_result",   bus.out_result, 32'h0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    settle();
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    idle_in();
    check("alu_valid",    32'(bus.out_valid), 32'd1);
    check("alu_result",   bus.out_result, 32'h0000_1234);
    check("alu_writereg", 32'(bus.out_writereg), 32'd7);

    // Misaligned accesses and an earlier-stage exception pass straight through.
    issue(1, 0, 0, 2'd2, 0, 32'h0000_3001, 32'h0, 5'd8);
    tick();
    check("lw_mis_valid",    32'(bus.out_valid), 32'd1);
    check("lw_mis_adel",     32'(bus.out_adel), 32'd1);
    check("lw_mis_ades",     32'(bus.out_ades), 32'd0);
    check("lw_mis_badvaddr", bus.out_badvaddr, 32'h0000_3001);
    check("lw_mis_result",   bus.out_result, 32'h0000_3001);
    check("lw_mis_noreq",    32'(bus.dreq_valid), 32'd0);
    issue(0, 1, 0, 2'd2, 0, 32'h0000_4002, 32'h1111_2222, 5'd0);
    tick();
    check("sw_mis_ades",     32'(bus.out_ades), 32'd1);
    check("sw_mis_adel",     32'(bus.out_adel), 32'd0);
    check("sw_mis_badvaddr", bus.out_badvaddr, 32'h0000_4002);
    check("sw_mis_noreq",    32'(bus.dreq_valid), 32'd0);
    issue(1, 0, 0, 2'd2, 1, 32'h0000_5001, 32'h0, 5'd9);
    tick();
    idle_in();
    check("exc_adel",     32'(bus.out_adel), 32'd0);
    check("exc_badvaddr", bus.out_badvaddr, 32'h0);
    check("exc_result",   bus.out_result, 32'h0000_5001);
    check("exc_noreq",    32'(bus.dreq_valid), 32'd0);
    tick();
    check("exc_consumed", 32'(bus.out_valid), 32'd0);

    // Flush while waiting for data: drain the beat, produce no result.
    issue(1, 0, 0, 2'd1, 0, 32'h0000_6002, 32'h0, 5'd10);
    tick();
    idle_in();
    bus.dresp_addr_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    check("fl_data_noreq", 32'(bus.dreq_valid), 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_drain_ready", 32'(bus.in_ready), 32'd0);
    check("fl_drain_valid", 32'(bus.out_valid), 32'd0);
    check("fl_drain_noreq", 32'(bus.dreq_valid), 32'd0);
    tick();
    check("fl_drain_ready2", 32'(bus.in_ready), 32'd0);
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 32'h1234_5678;
    tick();
    bus.dresp_data_ok = 1'b0;
    check("fl_done_valid", 32'(bus.out_valid), 32'd0);
    check("fl_done_ready", 32'(bus.in_ready), 32'd1);

    // Signed halfword load from the upper lane, same-cycle addr_ok and data_ok.
    issue(1, 0, 1, 2'd1, 0, 32'h0000_6002, 32'h0, 5'd11);
    tick();
    idle_in();
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 32'h8001_0000;
    tick();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    check("lh_valid",  32'(bus.out_valid), 32'd1);
    check("lh_result", bus.out_result, 32'hFFFF_8001);

    // Flush before addr_ok withdraws the request.
    issue(1, 0, 0, 2'd2, 0, 32'h0000_7000, 32'h0, 5'd12);
    tick();
    idle_in();
    check("fa_dreq_valid", 32'(bus.dreq_valid), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fa_dropped", 32'(bus.dreq_valid), 32'd0);
    check("fa_ready",   32'(bus.in_ready), 32'd1);
    check("fa_valid",   32'(bus.out_valid), 32'd0);

    // Flush in IDLE clears a pending result and wins over a simultaneous offer.
    bus.out_ready = 1'b0;
    issue(0, 0, 0, 2'd2, 0, 32'h0000_AAAA, 32'h0, 5'd12);
    tick();
    idle_in();
    check("fi_pending", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fi_cleared", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    issue(0, 0, 0, 2'd2, 0, 32'h0000_BBBB, 32'h0, 5'd13);
    tick();
    bus.flush = 1'b0;
    check("fp_no_accept", 32'(bus.out_valid), 32'd0);
    check("fp_ready",     32'(bus.in_ready), 32'd1);
    tick();
    idle_in();
    check("fp_accepted", 32'(bus.out_valid), 32'd1);
    check("fp_result",   bus.out_result, 32'h0000_BBBB);

    // Asynchronous reset in the middle of a bus request.
    issue(1, 0, 0, 2'd2, 0, 32'h0000_8000, 32'h0, 5'd14);
    tick();
    idle_in();
    check("ar_dreq_valid", 32'(bus.dreq_valid), 32'd1);
    reset = 1'b1;
    settle();
    check("ar_dreq_dropped", 32'(bus.dreq_valid), 32'd0);
    check("ar_in_ready",     32'(bus.in_ready), 32'd1);
    check("ar_out_valid",    32'(bus.out_valid), 32'd0);
    check("ar_result",       bus.out_result, 32'h0);
    check("ar_writereg",     32'(bus.out_writereg), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_idle_noreq", 32'(bus.dreq_valid), 32'd0);
    check("ar_idle_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
